// File: rtl/iob_regfile_2p_clr.sv
// Two-port (1W/1R) register file with per-column write enables, selectable read
// latency, optional write-first bypass and a row-by-row clear engine.
module iob_regfile_2p_clr #(
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic [NUM_COL-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastRow = ADDR_WIDTH'(Depth - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_word;

  assign busy = (state_q == StClear);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastRow) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The array is left untouched in the reset cycle; the clear engine zeroes it afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int unsigned i = 0; i < NUM_COL; i++) begin
          if (we[i]) mem_q[waddr][i*COL_WIDTH +: COL_WIDTH] <= wdata[i*COL_WIDTH +: COL_WIDTH];
        end
      end
    end
  end

  // Write-first merge is per column so partial writes return a mix of new and stored bytes.
  always_comb begin
    rd_word = mem_q[raddr];
    if (BYPASS != 0 && !busy && waddr == raddr) begin
      for (int unsigned i = 0; i < NUM_COL; i++) begin
        if (we[i]) rd_word[i*COL_WIDTH +: COL_WIDTH] = wdata[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  if (RD_LAT == 0) begin : g_rd_comb
    assign rdata  = rd_word;
    assign rvalid = re & ~busy;
  end else begin : g_rd_reg
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else if (re && !busy) begin
        rdata_q  <= rd_word;
        rvalid_q <= 1'b1;
      end else begin
        rvalid_q <= 1'b0;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_iob_regfile_2p_clr.sv
// Directed bench for iob_regfile_2p_clr: registered write-first, registered read-old
// and combinational instances share one stimulus stream.
module tb_iob_regfile_2p_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic [3:0]  we = '0;
  logic [3:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [3:0]  raddr = '0;

  logic        busy, busy_nb, busy_c;
  logic [31:0] rdata, rdata_nb, rdata_c;
  logic        rvalid, rvalid_nb, rvalid_c;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iob_regfile_2p_clr #(.RD_LAT(1), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid)
  );

  iob_regfile_2p_clr #(.RD_LAT(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_nb), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_nb), .rvalid(rvalid_nb)
  );

  iob_regfile_2p_clr #(.RD_LAT(0), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_c), .we(we), .waddr(waddr),
    .wdata(wdata), .re(re), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c)
  );

  typedef struct {
    logic [3:0]  we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  raddr;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [31:0] exp_data_nb;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = '0;
    re = 1'b0;
    clear_req = 1'b0;
  endtask

  // Counts cycles until busy drops; an expired bound shows up as a wrong count.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 16; a++) begin
      re = 1'b1;
      raddr = 4'(a);
      step();
      check({name, " rvalid"}, 32'(rvalid), 32'd1);
      check({name, " rdata"}, rdata, 32'h0);
    end
    re = 1'b0;
  endtask

  initial begin
    //            we     waddr  wdata          re    raddr  valid  exp_data      exp_data_nb
    vecs[0] = '{4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000};
    vecs[1] = '{4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0, 1'b0, 32'h00000000, 32'h00000000};
    vecs[2] = '{4'h0, 4'd0, 32'h00000000, 1'b1, 4'd3, 1'b1, 32'hDE22BE44, 32'hDE22BE44};
    vecs[3] = '{4'hF, 4'd5, 32'hAAAAAAAA, 1'b0, 4'd0, 1'b0, 32'hDE22BE44, 32'hDE22BE44};
    vecs[4] = '{4'h3, 4'd5, 32'h12345678, 1'b1, 4'd5, 1'b1, 32'hAAAA5678, 32'hAAAAAAAA};
    vecs[5] = '{4'h0, 4'd0, 32'h00000000, 1'b1, 4'd5, 1'b1, 32'hAAAA5678, 32'hAAAA5678};
    vecs[6] = '{4'hF, 4'd7, 32'h0BADF00D, 1'b0, 4'd0, 1'b0, 32'hAAAA5678, 32'hAAAA5678};
    vecs[7] = '{4'h0, 4'd0, 32'h00000000, 1'b1, 4'd7, 1'b1, 32'h0BADF00D, 32'h0BADF00D};
    vecs[8] = '{4'h0, 4'd0, 32'h00000000, 1'b0, 4'd7, 1'b0, 32'h0BADF00D, 32'h0BADF00D};

    // Reset: one cycle, then 16 clear cycles.
    rst = 1'b1;
    step();
    check("reset busy", 32'(busy), 32'd1);
    check("reset busy_nb", 32'(busy_nb), 32'd1);
    check("reset busy_c", 32'(busy_c), 32'd1);
    check("reset rvalid", 32'(rvalid), 32'd0);
    check("reset rdata", rdata, 32'h0);
    rst = 1'b0;
    count_busy("busy after reset");
    read_all_zero("post-reset read");

    // Table vectors: combinational instance checked before the edge, registered after.
    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we;
      waddr = vecs[i].waddr;
      wdata = vecs[i].wdata;
      re = vecs[i].re;
      raddr = vecs[i].raddr;
      #1;
      check($sformatf("vec%0d comb rvalid", i), 32'(rvalid_c), 32'(vecs[i].re));
      if (vecs[i].re) check($sformatf("vec%0d comb rdata", i), rdata_c, vecs[i].exp_data);
      step();
      check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_data);
      check($sformatf("vec%0d nb rdata", i), rdata_nb, vecs[i].exp_data_nb);
    end
    idle_inputs();

    // Fill every row, then clear with a coincident write and traffic during busy.
    for (int a = 0; a < 16; a++) begin
      we = 4'hF;
      waddr = 4'(a);
      wdata = 32'hC0DE0000 | 32'(a);
      step();
    end
    we = 4'hF;
    waddr = 4'd2;
    wdata = 32'hFFFFFFFF;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clear busy", 32'(busy), 32'd1);
    we = 4'hF;
    waddr = 4'd4;
    wdata = 32'h55555555;
    re = 1'b1;
    raddr = 4'd4;
    begin
      int n;
      n = 0;
      while (busy && n < 40) begin
        clear_req = (n == 5);
        step();
        n++;
        check($sformatf("busy rvalid c%0d", n), 32'(rvalid), 32'd0);
      end
      idle_inputs();
      check("clear busy length", 32'(n), 32'd16);
    end
    read_all_zero("post-clear read");

    // Reset at clear row 9 restarts the sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int k = 0; k < 9; k++) step();
    check("mid-clear busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy("busy after mid-clear reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
